data_mem_responder: RTL and testbench

//  Memory-side responder for the CPU load/store port: serves word read/write requests over a valid/ready handshake.

---
 rtl/data_mem_responder_if.sv | 23 ++
 rtl/data_mem_responder.sv | 102 ++++++++++
 tb/tb_data_mem_responder.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_if.sv
// Load/store port between the CPU data-memory initiator and the word-array responder.
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Fixed-latency word memory responder: one outstanding load/store, byte enables,
// misaligned / out-of-range accesses reported through rsp_err.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic                clk,
  input  logic                rst,
  data_mem_responder_if.slave bus
);
  localparam int AW    = $clog2(DEPTH_WORDS);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              wr_q;
  logic [31:0]       addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        be_q;
  logic              accept, commit, done;
  logic              err;
  logic [AW-1:0]     idx;
  logic [31:0]       mem [DEPTH_WORDS];

  // Range check on the full address so high bits never alias into the array.
  assign err = (addr_q[1:0] != 2'b00) | (|addr_q[31:AW+2]);
  assign idx = addr_q[AW+1:2];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    bus.req_ready = 1'b0;
    accept        = 1'b0;
    commit        = 1'b0;
    done          = 1'b0;
    case (state)
      IDLE: begin
        // Held low for the whole reset window, not just after it.
        bus.req_ready = rst;
        accept        = bus.req_valid & rst;
        if (accept) state_nxt = WAIT;
      end
      WAIT: begin
        if (cnt == '0) begin
          commit    = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        done = bus.rsp_ready;
        if (done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt           <= '0;
      wr_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      be_q          <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
    end else begin
      if (accept) begin
        cnt     <= CNT_W'(LATENCY - 1);
        wr_q    <= bus.req_write;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        be_q    <= bus.req_be;
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (commit) begin
        bus.rsp_valid <= 1'b1;
        bus.rsp_err   <= err;
        bus.rsp_rdata <= (!wr_q && !err) ? mem[idx] : 32'h0;
      end else if (done) begin
        bus.rsp_valid <= 1'b0;
        bus.rsp_rdata <= '0;
        bus.rsp_err   <= 1'b0;
      end
    end
  end

  // Array is not reset; commit can only fire out of WAIT, which reset clears.
  always_ff @(posedge clk) begin
    if (commit && wr_q && !err) begin
      for (int b = 0; b < 4; b++)
        if (be_q[b]) mem[idx][8*b +: 8] <= wdata_q[8*b +: 8];
    end
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: vector table plus back-pressure and mid-transaction reset.
module tb_data_mem_responder;
  localparam int DEPTH_WORDS = 256;
  localparam int LATENCY     = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  data_mem_responder_if bus();

  data_mem_responder #(.DEPTH_WORDS(DEPTH_WORDS), .LATENCY(LATENCY)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[18];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic send(input logic w, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
    int n;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_wdata = wd;
    bus.req_be    = be;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n == 50) chk("req_ready_timeout", 32'(n), 32'd0);
    @(posedge clk);
    #1;
    // Scribble the request lines: must not affect the accepted transaction.
    bus.req_valid = 1'b0;
    bus.req_write = ~w;
    bus.req_addr  = 32'h0000_0004;
    bus.req_wdata = 32'hBAD0_BAD0;
    bus.req_be    = 4'hF;
  endtask

  task automatic wait_rsp(input string tag);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (bus.rsp_valid !== 1'b1 && n < 50);
    chk({tag, "_latency"}, 32'(n), 32'(LATENCY));
  endtask

  task automatic ack(input string tag);
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    chk({tag, "_valid_drop"}, {31'd0, bus.rsp_valid}, 32'd0);
    chk({tag, "_rdata_clr"}, bus.rsp_rdata, 32'd0);
    chk({tag, "_err_clr"}, {31'd0, bus.rsp_err}, 32'd0);
    chk({tag, "_ready_back"}, {31'd0, bus.req_ready}, 32'd1);
  endtask

  task automatic txn(input string tag, input logic w, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] be, input logic [31:0] er, input logic ee);
    send(w, a, wd, be);
    wait_rsp(tag);
    chk({tag, "_rdata"}, bus.rsp_rdata, er);
    chk({tag, "_err"}, {31'd0, bus.rsp_err}, {31'd0, ee});
    ack(tag);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 32'h10,       32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 32'h10,       32'h0,        4'hF, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h20,       32'h11223344, 4'hF, 32'h0,        1'b0};
    vecs[3]  = '{1'b1, 32'h20,       32'hAABBCCDD, 4'h5, 32'h0,        1'b0};
    vecs[4]  = '{1'b0, 32'h20,       32'h0,        4'hF, 32'h11BB33DD, 1'b0};
    vecs[5]  = '{1'b0, 32'h13,       32'h0,        4'hF, 32'h0,        1'b1};
    vecs[6]  = '{1'b0, 32'h400,      32'h0,        4'hF, 32'h0,        1'b1};
    vecs[7]  = '{1'b1, 32'h12,       32'hFFFFFFFF, 4'hF, 32'h0,        1'b1};
    vecs[8]  = '{1'b0, 32'h10,       32'h0,        4'hF, 32'hDEADBEEF, 1'b0};
    vecs[9]  = '{1'b1, 32'h0,        32'h12345678, 4'hF, 32'h0,        1'b0};
    vecs[10] = '{1'b1, 32'h400,      32'hFFFFFFFF, 4'hF, 32'h0,        1'b1};
    vecs[11] = '{1'b0, 32'h0,        32'h0,        4'hF, 32'h12345678, 1'b0};
    vecs[12] = '{1'b1, 32'h10,       32'h0,        4'h0, 32'h0,        1'b0};
    vecs[13] = '{1'b0, 32'h10,       32'h0,        4'hF, 32'hDEADBEEF, 1'b0};
    vecs[14] = '{1'b1, 32'h3FC,      32'hCAFEF00D, 4'hF, 32'h0,        1'b0};
    vecs[15] = '{1'b0, 32'h3FC,      32'h0,        4'hF, 32'hCAFEF00D, 1'b0};
    vecs[16] = '{1'b0, 32'hFFFFFFFC, 32'h0,        4'hF, 32'h0,        1'b1};
    vecs[17] = '{1'b1, 32'h30,       32'h0,        4'hF, 32'h0,        1'b0};

    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_be    = '0;
    bus.rsp_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("rst_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_req_ready", {31'd0, bus.req_ready}, 32'd1);

    for (int i = 0; i < 18; i++)
      txn($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be,
          vecs[i].exp_rdata, vecs[i].exp_err);

    // Back-pressure: response held 10 cycles while a store is offered
    send(1'b0, 32'h10, 32'h0, 4'hF);
    wait_rsp("bp");
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 32'h10;
    bus.req_wdata = 32'h55555555;
    bus.req_be    = 4'hF;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("bp_valid_c%0d", c), {31'd0, bus.rsp_valid}, 32'd1);
      chk($sformatf("bp_rdata_c%0d", c), bus.rsp_rdata, 32'hDEADBEEF);
      chk($sformatf("bp_ready_c%0d", c), {31'd0, bus.req_ready}, 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    chk("bp_hs_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("bp_hs_idle", {31'd0, bus.req_ready}, 32'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    chk("bp_accepted", {31'd0, bus.req_ready}, 32'd0);
    wait_rsp("bp_st");
    chk("bp_st_err", {31'd0, bus.rsp_err}, 32'd0);
    ack("bp_st");
    txn("bp_ld", 1'b0, 32'h10, 32'h0, 4'hF, 32'h55555555, 1'b0);

    // Reset during WAIT of a store: nothing written, no response
    send(1'b1, 32'h30, 32'hFFFFFFFF, 4'hF);
    rst = 1'b0;
    #1;
    chk("mr_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("mr_ready", {31'd0, bus.req_ready}, 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("mr_valid_c%0d", c), {31'd0, bus.rsp_valid}, 32'd0);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mr_rel_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("mr_rel_valid", {31'd0, bus.rsp_valid}, 32'd0);
    txn("mr_ld", 1'b0, 32'h30, 32'h0, 4'hF, 32'h0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end
endmodule
